spi_shift_engine: RTL and testbench

//  Bit-level SPI master (mode 0: CPOL=0, CPHA=0, MSB first) between the TX/RX byte FIFOs and the

---
 rtl/spi_shift_engine_pkg.sv | 29 ++
 rtl/spi_shift_engine_clk_gen.sv | 53 +++++
 rtl/spi_shift_engine.sv | 148 ++++++++++++++
 tb/tb_spi_shift_engine.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_engine_pkg.sv
// spi_shift_engine_pkg
//   Shared definitions for the SPI shift engine: FSM state encodings,
//   SPI mode 0 clock polarity, default timing parameters and a counter
//   width helper.
package spi_shift_engine_pkg;

    // FSM state encodings (3 bits)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_POP   = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_PUSH  = 3'd5;
    localparam logic [2:0] ST_WAIT  = 3'd6;
    localparam logic [2:0] ST_GAP   = 3'd7;

    // SPI mode 0: sclk idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_CS_SETUP = 2;
    localparam int unsigned DEF_CS_GAP   = 4;

    // Bits needed for a counter that runs 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_shift_engine_clk_gen.sv
// spi_shift_engine_clk_gen
//   Half-period divider for the SPI clock. While en=1, sclk toggles every
//   CLK_DIV clk cycles; rise/fall are one-cycle strobes asserted in the
//   cycle whose closing clk edge moves sclk 0->1 / 1->0. While en=0 the
//   divider is cleared and sclk is held at its idle level.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous reset, active high
//   en    in  run the divider
//   sclk  out registered SPI clock
//   rise  out strobe: sclk rises at the next clk edge
//   fall  out strobe: sclk falls at the next clk edge
module spi_shift_engine_clk_gen
    import spi_shift_engine_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    always_comb begin
        wrap = en && (cnt == LAST);
        rise = wrap && !sclk;
        fall = wrap && sclk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= SPI_CPOL;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= SPI_CPOL;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   Bit-level SPI master (mode 0, MSB first) between TX/RX byte FIFOs and
//   the PmodACL2 pins. Pops a TX byte, shifts it out on mosi while
//   capturing miso, pushes the received byte to the RX FIFO, and keeps
//   cs_n low across consecutive bytes (and while cs_hold=1) so multi-byte
//   ADXL362 commands stay in one frame.
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   tx_fifo_read    out one-cycle pop strobe; tx_fifo_data valid next cycle
//   tx_fifo_data    in  TX FIFO head
//   tx_fifo_empty   in  TX FIFO empty
//   rx_fifo_write   out one-cycle push strobe
//   rx_fifo_data    out received byte, valid while rx_fifo_write=1
//   rx_fifo_full    in  RX FIFO full
//   cs_hold         in  keep cs_n low between bytes while TX FIFO is empty
//   busy            out engine not idle
//   sclk/mosi/cs_n  out SPI pins
//   miso            in  SPI data in (two-flop synchronised internally)
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_GAP   = DEF_CS_GAP
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tx_fifo_read,
    input  logic [7:0] tx_fifo_data,
    input  logic       tx_fifo_empty,
    output logic       rx_fifo_write,
    output logic [7:0] rx_fifo_data,
    input  logic       rx_fifo_full,
    input  logic       cs_hold,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam int unsigned TMAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int unsigned TW   = cnt_width(TMAX);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP - 1);

    logic [2:0]    state;
    logic [TW-1:0] tmr;
    logic [6:0]    shift_reg;   // bits still to send after the one on mosi
    logic [7:0]    rx_reg;
    logic [2:0]    bit_cnt;
    logic [1:0]    miso_sync;
    logic          start;
    logic          sck_rise;
    logic          sck_fall;

    always_comb begin
        start         = !tx_fifo_empty && !rx_fifo_full;
        tx_fifo_read  = (state == ST_POP);
        rx_fifo_write = (state == ST_PUSH);
        busy          = (state != ST_IDLE);
    end

    spi_shift_engine_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_SHIFT),
        .sclk (sclk),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            tmr          <= '0;
            shift_reg    <= '0;
            rx_reg       <= '0;
            bit_cnt      <= '0;
            miso_sync    <= '0;
            mosi         <= 1'b0;
            cs_n         <= 1'b1;
            rx_fifo_data <= '0;
        end else begin
            miso_sync <= {miso_sync[0], miso};
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SETUP;
                        cs_n  <= 1'b0;
                        tmr   <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tmr == SETUP_LAST) state <= ST_POP;
                    else                   tmr   <= tmr + TW'(1);
                end
                ST_POP: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    mosi      <= tx_fifo_data[7];
                    shift_reg <= tx_fifo_data[6:0];
                    rx_reg    <= '0;
                    bit_cnt   <= '0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sck_rise) rx_reg <= {rx_reg[6:0], miso_sync[1]};
                    if (sck_fall) begin
                        mosi      <= shift_reg[6];
                        shift_reg <= {shift_reg[5:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                        // 8th falling edge: rx_reg already holds all 8 samples
                        if (bit_cnt == 3'd7) begin
                            state        <= ST_PUSH;
                            rx_fifo_data <= rx_reg;
                        end
                    end
                end
                // PUSH and WAIT share their exit rules; a blocked start
                // (RX full) falls back to WAIT or GAP depending on cs_hold.
                ST_PUSH, ST_WAIT: begin
                    if (start) begin
                        state <= ST_POP;
                    end else if (cs_hold) begin
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_GAP;
                        cs_n  <= 1'b1;
                        tmr   <= '0;
                    end
                end
                ST_GAP: begin
                    if (tmr == GAP_LAST) state <= ST_IDLE;
                    else                 tmr   <= tmr + TW'(1);
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;

    localparam int MAIN_DIV   = 4;
    localparam int MAIN_SETUP = 2;
    localparam int MAIN_GAP   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_fifo_read;
    logic [7:0] tx_fifo_data = 8'h00;
    logic       tx_fifo_empty = 1'b1;
    logic       rx_fifo_write;
    logic [7:0] rx_fifo_data;
    logic       rx_fifo_full = 1'b0;
    logic       cs_hold = 1'b0;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    logic       loop = 1'b1;
    logic       slave_bit = 1'b0;

    logic [1:0] aux_empty = 2'b11;
    logic [1:0] a_read, a_write, a_busy, a_sclk, a_mosi, a_cs_n;
    logic [7:0] a_rxd [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso = loop ? mosi : slave_bit;

    spi_shift_engine #(.CLK_DIV(MAIN_DIV), .CS_SETUP(MAIN_SETUP), .CS_GAP(MAIN_GAP)) u_dut (
        .clk(clk), .rst(rst), .tx_fifo_read(tx_fifo_read), .tx_fifo_data(tx_fifo_data),
        .tx_fifo_empty(tx_fifo_empty), .rx_fifo_write(rx_fifo_write), .rx_fifo_data(rx_fifo_data),
        .rx_fifo_full(rx_fifo_full), .cs_hold(cs_hold), .busy(busy), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n));

    spi_shift_engine #(.CLK_DIV(2), .CS_SETUP(2), .CS_GAP(4)) u_div2 (
        .clk(clk), .rst(rst), .tx_fifo_read(a_read[0]), .tx_fifo_data(8'h3C),
        .tx_fifo_empty(aux_empty[0]), .rx_fifo_write(a_write[0]), .rx_fifo_data(a_rxd[0]),
        .rx_fifo_full(1'b0), .cs_hold(1'b0), .busy(a_busy[0]), .sclk(a_sclk[0]),
        .mosi(a_mosi[0]), .miso(1'b1), .cs_n(a_cs_n[0]));

    spi_shift_engine #(.CLK_DIV(7), .CS_SETUP(2), .CS_GAP(4)) u_div7 (
        .clk(clk), .rst(rst), .tx_fifo_read(a_read[1]), .tx_fifo_data(8'h3C),
        .tx_fifo_empty(aux_empty[1]), .rx_fifo_write(a_write[1]), .rx_fifo_data(a_rxd[1]),
        .rx_fifo_full(1'b0), .cs_hold(1'b0), .busy(a_busy[1]), .sclk(a_sclk[1]),
        .mosi(a_mosi[1]), .miso(1'b1), .cs_n(a_cs_n[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- TX FIFO model (head registered on pop) -------------
    logic [7:0] txq[$];
    always @(posedge clk) begin
        if (tx_fifo_read && txq.size() > 0) tx_fifo_data <= txq.pop_front();
        tx_fifo_empty <= (txq.size() == 0);
    end

    // ---------------- SPI slave: shifts response bytes out MSB first -----
    logic [7:0] respq[$];
    int   s_bit = 0;
    logic s_prev = 1'b0;
    logic [7:0] s_byte;
    always @(negedge clk) begin
        if (rst || cs_n) s_bit = 0;
        else if (sclk && !s_prev) begin
            s_bit++;
            if (s_bit == 8) begin
                s_bit = 0;
                if (respq.size() > 0) void'(respq.pop_front());
            end
        end
        s_prev = sclk;
        if (respq.size() > 0) begin
            s_byte = respq[0];
            slave_bit = s_byte[7 - s_bit];
        end else slave_bit = 1'b0;
    end

    // ---------------- Reference model: expected bytes on each side -------
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_log[$];
    logic       mosi_log[$];
    int n_reads = 0, n_writes = 0, n_rises = 0, n_cs_fall = 0, n_cs_rise = 0;

    task automatic send(input logic [7:0] b, input logic [7:0] resp);
        txq.push_back(b);
        exp_mosi.push_back(b);
        if (loop) exp_rx.push_back(b);
        else begin
            respq.push_back(resp);
            exp_rx.push_back(resp);
        end
    endtask

    // ---------------- Compare process ------------------------------------
    int   m_bits = 0, m_last_edge = 0, gap_run = 0;
    logic m_prev_sclk = 1'b0, m_prev_mosi = 1'b0, m_prev_cs = 1'b1;
    logic [7:0] m_sr = 8'h00;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_bits = 0; gap_run = 0;
            m_prev_sclk = 1'b0; m_prev_mosi = 1'b0; m_prev_cs = 1'b1;
        end else begin
            if (tx_fifo_read || rx_fifo_write) chk("rd_wr_exclusive", tx_fifo_read & rx_fifo_write, 0);
            if (tx_fifo_read) n_reads++;
            if (rx_fifo_write) begin
                n_writes++;
                rx_log.push_back(rx_fifo_data);
                chk("rx_expected_avail", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) chk("rx_data", rx_fifo_data, exp_rx.pop_front());
            end
            if (cs_n) chk("sclk_idle_cs_high", sclk, 0);
            if (!busy) chk("cs_high_when_idle", cs_n, 1);
            if (mosi != m_prev_mosi) chk("mosi_change_sclk_low", sclk, 0);
            if (sclk != m_prev_sclk) begin
                if (!(sclk && m_bits == 0)) chk("half_period", cyc - m_last_edge, MAIN_DIV);
                m_last_edge = cyc;
            end
            if (sclk && !m_prev_sclk) begin
                n_rises++;
                chk("cs_low_at_rise", cs_n, 0);
                m_sr = {m_sr[6:0], mosi};
                mosi_log.push_back(mosi);
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    chk("mosi_expected_avail", exp_mosi.size() > 0, 1);
                    if (exp_mosi.size() > 0) chk("mosi_byte", m_sr, exp_mosi.pop_front());
                end
            end
            if (cs_n && busy) gap_run++;
            else begin
                if (gap_run > 0) chk("gap_length", gap_run, MAIN_GAP);
                gap_run = 0;
            end
            if (!m_prev_cs && cs_n) n_cs_rise++;
            if (m_prev_cs && !cs_n) n_cs_fall++;
            m_prev_sclk = sclk; m_prev_mosi = mosi; m_prev_cs = cs_n;
        end
    end

    // ---------------- Bounded waits -------------------------------------
    task automatic wait_writes(input int target);
        int n = 0;
        while (n_writes < target && n < 2000) begin @(negedge clk); n++; end
        chk("rx_push_count", n_writes, target);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || txq.size() > 0) && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("returns_idle", busy, 0);
    endtask

    task automatic measure(input int k, input int d);
        int n, t0, t1, last, rises, bad, halves;
        logic prev;
        logic [7:0] rxv;
        @(negedge clk);
        aux_empty[k] = 1'b0;
        n = 0;
        while (!a_read[k] && n < 100) begin @(negedge clk); n++; end
        chk($sformatf("div%0d_pop_seen", d), a_read[k], 1);
        t0 = cyc; t1 = cyc; aux_empty[k] = 1'b1;
        prev = a_sclk[k]; last = -1; rises = 0; bad = 0; halves = 0; rxv = 8'h00;
        n = 0;
        while (n < 32 * d + 20) begin
            @(negedge clk); n++;
            if (a_sclk[k] != prev) begin
                if (last >= 0) begin
                    halves++;
                    if (cyc - last != d) bad++;
                end
                if (a_sclk[k]) rises++;
                last = cyc; prev = a_sclk[k];
            end
            if (a_write[k]) begin t1 = cyc; rxv = a_rxd[k]; break; end
        end
        chk($sformatf("div%0d_bad_half_periods", d), bad, 0);
        chk($sformatf("div%0d_half_periods", d), halves, 15);
        chk($sformatf("div%0d_rises", d), rises, 8);
        chk($sformatf("div%0d_pop_to_push", d), t1 - t0, 16 * d + 2);
        chk($sformatf("div%0d_rx", d), rxv, 8'hFF);
        n = 0;
        while (a_busy[k] && n < 50) begin @(negedge clk); n++; end
        chk($sformatf("div%0d_idle", d), a_busy[k], 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, ml0, rl0, f0, c0, rd0, bad_cs, bad_sclk, n;
        logic [7:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {sclk, mosi, cs_n, tx_fifo_read, rx_fifo_write, busy, rx_fifo_data},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single byte, loopback
        loop = 1'b1;
        w0 = n_writes; r0 = n_rises; ml0 = mosi_log.size(); rl0 = rx_log.size();
        f0 = n_cs_fall; c0 = n_cs_rise;
        send(8'hA5, 8'h00);
        wait_writes(w0 + 1);
        wait_idle();
        v = 8'h00;
        for (int i = 0; i < 8; i++) v = {v[6:0], mosi_log[ml0 + i]};
        chk("t1_mosi_bits", v, 8'hA5);
        chk("t1_rx", rx_log[rl0], 8'hA5);
        chk("t1_rises", n_rises - r0, 8);
        chk("t1_frames", {n_cs_fall - f0, n_cs_rise - c0}, {32'd1, 32'd1});

        // 2: 3-byte burst, slave answers 0xAD on the third byte
        loop = 1'b0;
        w0 = n_writes; rl0 = rx_log.size(); f0 = n_cs_fall; c0 = n_cs_rise;
        send(8'h0B, 8'h00); send(8'h00, 8'h00); send(8'h00, 8'hAD);
        wait_writes(w0 + 3);
        wait_idle();
        chk("t2_rx0", rx_log[rl0], 8'h00);
        chk("t2_rx1", rx_log[rl0 + 1], 8'h00);
        chk("t2_rx2", rx_log[rl0 + 2], 8'hAD);
        chk("t2_single_frame", {n_cs_fall - f0, n_cs_rise - c0}, {32'd1, 32'd1});

        // 3: cs_hold keeps the frame open across an empty TX FIFO
        loop = 1'b1; cs_hold = 1'b1;
        w0 = n_writes; f0 = n_cs_fall; c0 = n_cs_rise;
        send(8'h0A, 8'h00);
        wait_writes(w0 + 1);
        bad_cs = 0; bad_sclk = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cs_n) bad_cs++;
            if (sclk) bad_sclk++;
        end
        chk("t3_cs_held", bad_cs, 0);
        chk("t3_sclk_idle", bad_sclk, 0);
        send(8'h2D, 8'h00);
        wait_writes(w0 + 2);
        repeat (10) @(negedge clk);
        chk("t3_cs_still_low", cs_n, 0);
        cs_hold = 1'b0;
        wait_idle();
        chk("t3_single_frame", {n_cs_fall - f0, n_cs_rise - c0}, {32'd1, 32'd1});
        chk("t3_rx_last", rx_log[rx_log.size() - 1], 8'h2D);

        // 4: RX FIFO full blocks the start
        rx_fifo_full = 1'b1;
        rd0 = n_reads; w0 = n_writes;
        send(8'h55, 8'h00);
        repeat (30) @(negedge clk);
        chk("t4_no_pop", n_reads - rd0, 0);
        chk("t4_cs_high", cs_n, 1);
        rx_fifo_full = 1'b0;
        wait_writes(w0 + 1);
        wait_idle();
        chk("t4_rx", rx_log[rx_log.size() - 1], 8'h55);

        // 5: reset after the 4th sclk rise aborts the byte
        r0 = n_rises;
        send(8'hC3, 8'h00);
        n = 0;
        while (n_rises < r0 + 4 && n < 500) begin @(negedge clk); n++; end
        chk("t5_four_rises", n_rises - r0, 4);
        rst = 1'b1;
        #1;
        chk("t5_abort_outputs", {cs_n, sclk, busy, rx_fifo_write}, 4'b1000);
        void'(exp_mosi.pop_front());
        void'(exp_rx.pop_front());
        w0 = n_writes;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_no_push_after_abort", n_writes - w0, 0);
        send(8'h3E, 8'h00);
        wait_writes(w0 + 1);
        wait_idle();
        chk("t5_clean_rx", rx_log[rx_log.size() - 1], 8'h3E);

        // 6: divider extremes
        measure(0, 2);
        measure(1, 7);

        // Randomised traffic
        for (int it = 0; it < 12; it++) begin
            int nb;
            loop = 1'($urandom_range(0, 1));
            cs_hold = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            w0 = n_writes;
            for (int b = 0; b < nb; b++) begin
                send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                rx_fifo_full = ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rx_fifo_full = 1'b0;
            end
            wait_writes(w0 + nb);
            cs_hold = 1'b0;
            wait_idle();
        end
        chk("model_queues_drained", {exp_mosi.size(), exp_rx.size()}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
